// File: rtl/vr_lsu_pkg.sv
// Shared encodings and small helpers for the load/store unit.
package vr_lsu_pkg;

  // Access size encodings as seen on the request SIZE field
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  // True when the size/offset pair cannot be served as one aligned access
  function automatic logic accessMisaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Memory is word-addressed; drop the byte offset
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Little-endian byte lane pick
  function automatic logic [7:0] laneByte(input logic [31:0] word, input logic [1:0] off);
    case (off)
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      2'd3:    return word[31:24];
      default: return word[7:0];
    endcase
  endfunction

  // Half lane pick: offset bit 1 selects the upper half
  function automatic logic [15:0] laneHalf(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/vr_load_store_unit_if.sv
// Core request/response handshake plus the word-wide memory port.
interface vr_load_store_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] m_addr;
  logic        m_rw;
  logic [31:0] m_wd;
  logic [31:0] m_rd;

  // Environment side: the core issues requests and the memory returns read data
  modport master (
    output req, we, size, sgn, addr, wdata, m_rd,
    input  ready, done, err, rdata, m_addr, m_rw, m_wd
  );

  // Load/store unit side
  modport slave (
    input  req, we, size, sgn, addr, wdata, m_rd,
    output ready, done, err, rdata, m_addr, m_rw, m_wd
  );
endinterface

// File: rtl/vr_lsu_lane.sv
// Lane datapath: extracts and extends load data, and inserts store data
// into a read word for sub-word read-modify-write.
module vr_lsu_lane
  import vr_lsu_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        sgn_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Select the addressed lane and widen it to 32 bits
  always_comb begin
    byteSel = laneByte(rd_word_i, offset_i);
    halfSel = laneHalf(rd_word_i, offset_i[1]);
    case (size_i)
      SZ_B:    load_data_o = {{24{sgn_i & byteSel[7]}}, byteSel};
      SZ_H:    load_data_o = {{16{sgn_i & halfSel[15]}}, halfSel};
      default: load_data_o = rd_word_i;
    endcase
  end

  // Overwrite only the addressed lane(s) of the word read from memory
  always_comb begin
    merged_o = rd_word_i;
    case (size_i)
      SZ_B: begin
        case (offset_i)
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          2'd3:    merged_o[31:24] = wdata_i[7:0];
          default: merged_o[7:0]   = wdata_i[7:0];
        endcase
      end
      SZ_H: begin
        if (offset_i[1]) merged_o[31:16] = wdata_i;
        else             merged_o[15:0]  = wdata_i;
      end
      default: merged_o = rd_word_i;
    endcase
  end

endmodule

// File: rtl/vr_load_store_unit.sv
// Memory-stage load/store unit: one request at a time, sub-word stores
// done as read-modify-write, all memory port signals registered.
module vr_load_store_unit
  import vr_lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
)
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  vr_load_store_unit_if.slave  bus
);

  lsu_state_e  state_q;
  logic        ready_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mAddr_q;
  logic        mRw_q;
  logic [31:0] mWd_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [1:0]  offset_q;
  logic [15:0] wdata_q;

  logic        reqBad;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  assign reqBad = accessMisaligned(bus.size, bus.addr[1:0]) ||
                  (bus.addr >= 32'(MEM_BYTES));

  vr_lsu_lane u_lane (
    .rd_word_i   (bus.m_rd),
    .wdata_i     (wdata_q),
    .size_i      (size_q),
    .offset_i    (offset_q),
    .sgn_i       (sgn_q),
    .load_data_o (loadData),
    .merged_o    (mergedWord)
  );

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
  assign bus.m_addr = mAddr_q;
  assign bus.m_rw   = mRw_q;
  assign bus.m_wd   = mWd_q;

  // Request FSM; every output is a register so memory never sees live core inputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      mAddr_q  <= '0;
      mRw_q    <= 1'b0;
      mWd_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= SZ_B;
      sgn_q    <= 1'b0;
      offset_q <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (bus.req) begin
            ready_q  <= 1'b0;
            we_q     <= bus.we;
            size_q   <= bus.size;
            sgn_q    <= bus.sgn;
            offset_q <= bus.addr[1:0];
            wdata_q  <= bus.wdata[15:0];
            if (reqBad) begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_ACCESS;
              mAddr_q <= wordAlign(bus.addr);
              if (bus.we && bus.size == SZ_W) begin
                mRw_q <= 1'b1;
                mWd_q <= bus.wdata;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            rdata_q <= loadData;
            state_q <= ST_RESP;
            done_q  <= 1'b1;
          end else if (size_q == SZ_W) begin
            mRw_q   <= 1'b0;
            state_q <= ST_RESP;
            done_q  <= 1'b1;
          end else begin
            mWd_q   <= mergedWord;
            mRw_q   <= 1'b1;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          mRw_q   <= 1'b0;
          state_q <= ST_RESP;
          done_q  <= 1'b1;
        end
        ST_RESP: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          mRw_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vr_load_store_unit.sv
// Bench for vr_load_store_unit with a word memory model and a byte-level
// reference of what memory and RDATA should hold.
module tb_vr_load_store_unit;
  import vr_lsu_pkg::*;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

  vr_load_store_unit_if bus();

  vr_load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Word memory: combinational read, write on rising edge while m_rw is high
  logic [31:0] mem [256];
  assign bus.m_rd = bus.m_rw ? 32'h0 : mem[bus.m_addr[9:2]];
  always @(posedge clk) begin
    if (bus.m_rw) mem[bus.m_addr[9:2]] <= bus.m_wd;
  end

  // Reference byte image and expected RDATA
  logic [7:0]  refb [1024];
  logic [31:0] expRdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expRdata;
    int          expLat;
    int          expRw;
  } vec_t;

  vec_t vecs[11];

  function automatic logic refErr(input logic [1:0] size, input logic [31:0] addr);
    int n;
    if (size == 2'b11) return 1'b1;
    n = 1 << size;
    return (addr >= 1024) || ((addr % n) != 0);
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(refb[addr + i]) << (8 * i));
    if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic refStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 1 << size;
    for (int i = 0; i < n; i++) refb[addr + i] = 8'(wdata >> (8 * i));
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for READY at a falling edge, then present a request
  task automatic issueRequest(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (!bus.ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.ready) checkOutput("readyTimeout", {31'b0, bus.ready}, 32'd1);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.size  = size;
    bus.sgn   = sgn;
    bus.addr  = addr;
    bus.wdata = wdata;
  endtask

  // Run one full transaction; latency counts edges from accept to DONE
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output int lat, output logic errOut, output logic [31:0] rdataOut,
                               output int rwCount, output int rwFirst);
    bit gotDone;
    issueRequest(we, size, sgn, addr, wdata);
    @(negedge clk);
    bus.req  = 1'b0;
    lat      = 1;
    rwCount  = 0;
    rwFirst  = 0;
    gotDone  = 0;
    errOut   = 1'b0;
    rdataOut = '0;
    while (lat <= 8) begin
      if (bus.m_rw) begin
        rwCount++;
        if (rwFirst == 0) rwFirst = lat;
      end
      if (bus.done) begin
        gotDone  = 1;
        errOut   = bus.err;
        rdataOut = bus.rdata;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!gotDone) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
      lat = -1;
    end
  endtask

  initial begin
    int lat, rwCount, rwFirst, accCyc[3], n, cyc, dones, bad;
    logic errOut;
    logic [31:0] rdataOut;
    logic we, sgn, expErr;
    logic [1:0] size;
    logic [31:0] addr, wdata, rdHold;

    testCount = 0;
    failCount = 0;
    bus.req = 0; bus.we = 0; bus.size = 0; bus.sgn = 0; bus.addr = 0; bus.wdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 1024; i++) refb[i] = '0;
    mem[0] = 32'h8899_AABB;
    mem[1] = 32'd9;
    refStore(SZ_W, 0, 32'h8899_AABB);
    refStore(SZ_W, 4, 32'd9);
    expRdata = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstReady", {31'b0, bus.ready}, 32'd1);
    checkOutput("rstDone",  {31'b0, bus.done},  32'd0);
    checkOutput("rstErr",   {31'b0, bus.err},   32'd0);
    checkOutput("rstRdata", bus.rdata, 32'd0);
    checkOutput("rstMRw",   {31'b0, bus.m_rw},  32'd0);
    checkOutput("rstMAddr", bus.m_addr, 32'd0);
    checkOutput("rstMWd",   bus.m_wd, 32'd0);
    rst = 1'b0;

    // Directed vectors against the preloaded memory
    vecs[0]  = '{0, SZ_W, 0, 32'd0,    32'h0,  0, 32'h8899_AABB, 2, 0};
    vecs[1]  = '{0, SZ_B, 1, 32'd1,    32'h0,  0, 32'hFFFF_FFAA, 2, 0};
    vecs[2]  = '{0, SZ_B, 0, 32'd1,    32'h0,  0, 32'h0000_00AA, 2, 0};
    vecs[3]  = '{0, SZ_B, 1, 32'd0,    32'h0,  0, 32'hFFFF_FFBB, 2, 0};
    vecs[4]  = '{0, SZ_H, 1, 32'd2,    32'h0,  0, 32'hFFFF_8899, 2, 0};
    vecs[5]  = '{1, SZ_B, 0, 32'd4,    32'h55, 0, 32'hFFFF_8899, 3, 1};
    vecs[6]  = '{1, SZ_H, 0, 32'd3,    32'h1234, 1, 32'hFFFF_8899, 1, 0};
    vecs[7]  = '{0, SZ_W, 0, 32'd1024, 32'h0,  1, 32'hFFFF_8899, 1, 0};
    vecs[8]  = '{0, SZ_X, 0, 32'd0,    32'h0,  1, 32'hFFFF_8899, 1, 0};
    vecs[9]  = '{0, SZ_H, 1, 32'd4,    32'h0,  0, 32'h0000_0055, 2, 0};
    vecs[10] = '{0, SZ_W, 0, 32'd2,    32'h0,  1, 32'h0000_0055, 1, 0};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                    lat, errOut, rdataOut, rwCount, rwFirst);
      checkOutput($sformatf("vec%0d_lat", i),   32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d_err", i),   {31'b0, errOut}, {31'b0, vecs[i].expErr});
      checkOutput($sformatf("vec%0d_rdata", i), rdataOut, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d_rwCycles", i), 32'(rwCount), 32'(vecs[i].expRw));
      if (vecs[i].we && vecs[i].size != SZ_W && !vecs[i].expErr)
        checkOutput($sformatf("vec%0d_rwInWrite", i), 32'(rwFirst), 32'd2);
      if (vecs[i].we && !vecs[i].expErr) refStore(vecs[i].size, vecs[i].addr, vecs[i].wdata);
    end
    expRdata = 32'h0000_0055;
    checkOutput("word1AfterByteStore", mem[1], 32'h0000_0055);
    checkOutput("word0Untouched", mem[0], 32'h8899_AABB);

    // Reset during the WRITE cycle of a byte store: write still commits
    issueRequest(1, SZ_B, 0, 32'd8, 32'hA5);
    @(negedge clk);
    bus.req = 1'b0;
    checkOutput("rmwAccessRw", {31'b0, bus.m_rw}, 32'd0);
    @(negedge clk);
    checkOutput("rmwWriteRw", {31'b0, bus.m_rw}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstReady", {31'b0, bus.ready}, 32'd1);
    checkOutput("midRstDone",  {31'b0, bus.done},  32'd0);
    checkOutput("midRstMRw",   {31'b0, bus.m_rw},  32'd0);
    checkOutput("midRstMAddr", bus.m_addr, 32'd0);
    checkOutput("midRstMWd",   bus.m_wd, 32'd0);
    checkOutput("midRstRdata", bus.rdata, 32'd0);
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checkOutput("midRstNoDone", 32'(dones), 32'd0);
    checkOutput("midRstCommitted", mem[2], 32'h0000_00A5);
    refStore(SZ_B, 8, 32'hA5);
    expRdata = '0;

    // Reset during ACCESS of a byte store: nothing written
    issueRequest(1, SZ_B, 0, 32'd12, 32'h77);
    @(negedge clk);
    bus.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abortNoWrite", mem[3], 32'h0);
    checkOutput("abortReady", {31'b0, bus.ready}, 32'd1);

    // REQ held high across three word stores; busy-time requests are ignored
    n = 0; cyc = 0; dones = 0;
    @(negedge clk);
    bus.req = 1'b1;
    while (cyc < 40 && (n < 3 || dones < 3)) begin
      if (bus.done) dones++;
      if (bus.ready && n < 3) begin
        bus.we = 1; bus.size = SZ_W; bus.sgn = 0;
        bus.addr = 32'(16 + 4 * n);
        bus.wdata = 32'h1111_1111 * 32'(n + 1);
        accCyc[n] = cyc;
        n++;
      end else if (n >= 3) begin
        bus.req = 1'b0;
      end else begin
        bus.addr = 32'd28;
        bus.wdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      cyc++;
    end
    bus.req = 1'b0;
    checkOutput("b2bAccepts", 32'(n), 32'd3);
    checkOutput("b2bDones", 32'(dones), 32'd3);
    checkOutput("b2bSpacing01", 32'(accCyc[1] - accCyc[0]), 32'd3);
    checkOutput("b2bSpacing12", 32'(accCyc[2] - accCyc[1]), 32'd3);
    checkOutput("b2bWord4", mem[4], 32'h1111_1111);
    checkOutput("b2bWord5", mem[5], 32'h2222_2222);
    checkOutput("b2bWord6", mem[6], 32'h3333_3333);
    checkOutput("b2bIgnoredBusy", mem[7], 32'h0);
    for (int i = 0; i < 3; i++) refStore(SZ_W, 32'(16 + 4 * i), 32'h1111_1111 * 32'(i + 1));

    // Random traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      we   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      sgn  = 1'($urandom_range(0, 1));
      wdata = $urandom;
      if (r == 0)      addr = 32'd1016 + $urandom_range(0, 15);
      else if (r == 1) addr = $urandom;
      else             addr = $urandom_range(0, 63);
      expErr = refErr(size, addr);
      rdHold = expRdata;
      if (!expErr && !we) expRdata = refLoad(size, sgn, addr);
      applyStimulus(we, size, sgn, addr, wdata, lat, errOut, rdataOut, rwCount, rwFirst);
      checkOutput($sformatf("rnd%0d_err", i), {31'b0, errOut}, {31'b0, expErr});
      checkOutput($sformatf("rnd%0d_lat", i), 32'(lat),
                  expErr ? 32'd1 : (we && size != SZ_W) ? 32'd3 : 32'd2);
      checkOutput($sformatf("rnd%0d_rdata", i), rdataOut, (!expErr && !we) ? expRdata : rdHold);
      checkOutput($sformatf("rnd%0d_rwCycles", i), 32'(rwCount), (!expErr && we) ? 32'd1 : 32'd0);
      if (!expErr && we) refStore(size, addr, wdata);
    end

    // Whole memory image against the reference bytes
    @(negedge clk);
    bad = 0;
    for (int w = 0; w < 256; w++) begin
      if (mem[w] !== {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]}) bad++;
    end
    checkOutput("memImage", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
